// File: rtl/dense_pingpong_ctrl.sv
// Ping-pong input-vector controller for the dense layer: the producer fills one
// RAM bank while dense reads the other, and the two banks alternate strictly.
module dense_pingpong_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DIM     = 1568,
  parameter int AW         = $clog2(IN_DIM)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [1:0]            bank_we,
  output logic [AW-1:0]         bank_waddr,
  output logic [DATA_WIDTH-1:0] bank_wdata,
  output logic [1:0]            bank_re,
  output logic [AW-1:0]         bank_raddr,
  input  logic [DATA_WIDTH-1:0] bank_q0,
  input  logic [DATA_WIDTH-1:0] bank_q1,
  output logic                  dense_start,
  input  logic                  dense_in_en,
  input  logic [AW-1:0]         dense_in_addr,
  output logic [DATA_WIDTH-1:0] dense_in_q,
  input  logic                  dense_done,
  output logic                  frame_done,
  output logic [1:0]            bank_full,
  output logic                  err
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_state_e;
  typedef enum logic {R_IDLE, R_RUN} rd_state_e;

  bank_state_e r_bankState [2];
  bank_state_e w_bankNext  [2];
  rd_state_e   r_rdState;
  rd_state_e   w_rdNext;

  logic          r_wsel;
  logic          r_rsel;
  logic [AW-1:0] r_wcnt;
  logic          r_start;
  logic          r_frameDone;
  logic          r_err;

  logic w_accept;
  logic w_wrLast;
  logic w_launch;
  logic w_release;
  logic w_protoErr;

  assign wr_ready   = reset_n & ((r_bankState[r_wsel] == B_EMPTY) ||
                                 (r_bankState[r_wsel] == B_FILLING));
  assign w_accept   = wr_valid & wr_ready;
  assign w_wrLast   = w_accept && (r_wcnt == AW'(IN_DIM - 1));
  assign bank_we    = w_accept ? (r_wsel ? 2'b10 : 2'b01) : 2'b00;
  assign bank_waddr = r_wcnt;
  assign bank_wdata = wr_data;

  // rsel is fixed for a whole run, so the plain mux already lines up with bank latency
  assign dense_in_q  = r_rsel ? bank_q1 : bank_q0;
  assign dense_start = r_start;
  assign frame_done  = r_frameDone;
  assign err         = r_err;
  assign bank_full[0] = (r_bankState[0] == B_FULL) || (r_bankState[0] == B_READING);
  assign bank_full[1] = (r_bankState[1] == B_FULL) || (r_bankState[1] == B_READING);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdState <= R_IDLE;
    else          r_rdState <= w_rdNext;
  end

  always_comb begin
    w_rdNext = r_rdState;
    case (r_rdState)
      R_IDLE:  if (r_bankState[r_rsel] == B_FULL) w_rdNext = R_RUN;
      R_RUN:   if (dense_done) w_rdNext = R_IDLE;
      default: w_rdNext = R_IDLE;
    endcase
  end

  always_comb begin
    w_launch   = 1'b0;
    w_release  = 1'b0;
    bank_re    = 2'b00;
    bank_raddr = '0;
    case (r_rdState)
      R_IDLE: w_launch = (r_bankState[r_rsel] == B_FULL);
      R_RUN: begin
        bank_re    = dense_in_en ? (r_rsel ? 2'b10 : 2'b01) : 2'b00;
        bank_raddr = dense_in_addr;
        w_release  = dense_done;
      end
      default: ;
    endcase
  end

  assign w_protoErr = (r_rdState != R_RUN) && (dense_done || dense_in_en);

  // Writer and reader never own the same bank, so both updates can land in one cycle
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bankNext[b] = r_bankState[b];
      if (w_accept && (r_wsel == 1'(b)))
        w_bankNext[b] = w_wrLast ? B_FULL : B_FILLING;
      if (w_launch && (r_rsel == 1'(b)))
        w_bankNext[b] = B_READING;
      if (w_release && (r_rsel == 1'(b)))
        w_bankNext[b] = B_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bankState[0] <= B_EMPTY;
      r_bankState[1] <= B_EMPTY;
      r_wsel         <= 1'b0;
      r_rsel         <= 1'b0;
      r_wcnt         <= '0;
      r_start        <= 1'b0;
      r_frameDone    <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_bankState[0] <= w_bankNext[0];
      r_bankState[1] <= w_bankNext[1];
      if (w_accept) begin
        if (w_wrLast) begin
          r_wcnt <= '0;
          r_wsel <= ~r_wsel;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
      if (w_release) r_rsel <= ~r_rsel;
      r_start     <= w_launch;
      r_frameDone <= w_release;
      if (w_protoErr) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dense_pingpong_ctrl.sv
// Directed bench for dense_pingpong_ctrl: a small IN_DIM=4 instance for protocol
// scenarios and a full-size IN_DIM=1568 instance for a continuous throughput run.
module tb_dense_pingpong_ctrl;
  localparam int DW  = 16;
  localparam int SN  = 4;
  localparam int SAW = 2;
  localparam int LN  = 1568;
  localparam int LAW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic           s_reset_n, s_wr_valid, s_wr_ready, s_dense_start, s_in_en, s_done;
  logic           s_frame_done, s_err;
  logic [DW-1:0]  s_wr_data, s_bank_wdata, s_q0, s_q1, s_in_q;
  logic [1:0]     s_bank_we, s_bank_re, s_bank_full;
  logic [SAW-1:0] s_bank_waddr, s_bank_raddr, s_in_addr;

  logic           L_reset_n, L_wr_valid, L_wr_ready, L_dense_start, L_in_en, L_done;
  logic           L_frame_done, L_err;
  logic [DW-1:0]  L_wr_data, L_bank_wdata, L_q0, L_q1, L_in_q;
  logic [1:0]     L_bank_we, L_bank_re, L_bank_full;
  logic [LAW-1:0] L_bank_waddr, L_bank_raddr, L_in_addr;

  dense_pingpong_ctrl #(.DATA_WIDTH(DW), .IN_DIM(SN), .AW(SAW)) u_small (
    .clk(clk), .reset_n(s_reset_n), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .wr_data(s_wr_data), .bank_we(s_bank_we), .bank_waddr(s_bank_waddr),
    .bank_wdata(s_bank_wdata), .bank_re(s_bank_re), .bank_raddr(s_bank_raddr),
    .bank_q0(s_q0), .bank_q1(s_q1), .dense_start(s_dense_start), .dense_in_en(s_in_en),
    .dense_in_addr(s_in_addr), .dense_in_q(s_in_q), .dense_done(s_done),
    .frame_done(s_frame_done), .bank_full(s_bank_full), .err(s_err)
  );

  dense_pingpong_ctrl #(.DATA_WIDTH(DW), .IN_DIM(LN), .AW(LAW)) u_large (
    .clk(clk), .reset_n(L_reset_n), .wr_valid(L_wr_valid), .wr_ready(L_wr_ready),
    .wr_data(L_wr_data), .bank_we(L_bank_we), .bank_waddr(L_bank_waddr),
    .bank_wdata(L_bank_wdata), .bank_re(L_bank_re), .bank_raddr(L_bank_raddr),
    .bank_q0(L_q0), .bank_q1(L_q1), .dense_start(L_dense_start), .dense_in_en(L_in_en),
    .dense_in_addr(L_in_addr), .dense_in_q(L_in_q), .dense_done(L_done),
    .frame_done(L_frame_done), .bank_full(L_bank_full), .err(L_err)
  );

  // Single-clock RAM banks with one cycle of read latency
  logic [DW-1:0] sMem0 [SN];
  logic [DW-1:0] sMem1 [SN];
  logic [DW-1:0] lMem0 [LN];
  logic [DW-1:0] lMem1 [LN];

  always @(posedge clk) begin
    if (s_bank_we[0]) sMem0[s_bank_waddr] <= s_bank_wdata;
    if (s_bank_we[1]) sMem1[s_bank_waddr] <= s_bank_wdata;
    if (s_bank_re[0]) s_q0 <= sMem0[s_bank_raddr];
    if (s_bank_re[1]) s_q1 <= sMem1[s_bank_raddr];
    if (L_bank_we[0]) lMem0[L_bank_waddr] <= L_bank_wdata;
    if (L_bank_we[1]) lMem1[L_bank_waddr] <= L_bank_wdata;
    if (L_bank_re[0]) L_q0 <= lMem0[L_bank_raddr];
    if (L_bank_re[1]) L_q1 <= lMem1[L_bank_raddr];
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input int data, input logic inEn,
                               input int inAddr, input logic done);
    s_wr_valid = valid;
    s_wr_data  = 16'(data);
    s_in_en    = inEn;
    s_in_addr  = SAW'(inAddr);
    s_done     = done;
    #1;
  endtask

  task automatic doReset();
    s_wr_valid = 1'b0;
    s_in_en    = 1'b0;
    s_done     = 1'b0;
    s_reset_n  = 1'b0;
    #1;
    tick();
    s_reset_n = 1'b1;
    tick();
  endtask

  task automatic pushFrame(input int base, input logic [1:0] mask, input string tag);
    for (int i = 0; i < SN; i++) begin
      applyStimulus(1'b1, base + i, 1'b0, 0, 1'b0);
      checkOutput({tag, " we"}, s_bank_we, mask);
      checkOutput({tag, " waddr"}, s_bank_waddr, i);
      tick();
    end
    s_wr_valid = 1'b0;
  endtask

  task automatic readFrame(input logic [1:0] mask, input int base, input string tag);
    for (int a = 0; a <= SN; a++) begin
      applyStimulus(1'b0, 0, a < SN, (a < SN) ? a : 0, 1'b0);
      if (a < SN) checkOutput({tag, " re"}, s_bank_re, mask);
      if (a > 0)  checkOutput({tag, " q"}, s_in_q, base + a - 1);
      tick();
    end
  endtask

  function automatic logic [15:0] dataOf(input int f, input int a);
    return 16'(f * 4096 + a);
  endfunction

  // Continuous producer plus a LAT=1 dense model on the full-size instance
  task automatic runThroughput();
    int pf = 0, pi = 0, cf = 0, ra = 0, framesDone = 0, errs = 0, cycles = 0;
    bit running = 1'b0;
    bit accept;
    while (framesDone < 4 && cycles < 20000) begin
      L_wr_valid = (pf < 4);
      L_wr_data  = dataOf(pf, pi);
      L_done     = 1'b0;
      L_in_en    = 1'b0;
      L_in_addr  = '0;
      if (!running && L_dense_start) begin
        running = 1'b1;
        ra      = 0;
        errs    = 0;
      end
      if (running) begin
        if (ra > 0 && L_in_q !== dataOf(cf, ra - 1)) errs++;
        if (ra < LN) begin
          L_in_en   = 1'b1;
          L_in_addr = LAW'(ra);
          ra++;
        end else begin
          L_done  = 1'b1;
          running = 1'b0;
          checkOutput("tput frame data errors", errs, 0);
          cf++;
          framesDone++;
        end
      end
      #1;
      accept = L_wr_valid && L_wr_ready;
      tick();
      if (accept) begin
        pi++;
        if (pi == LN) begin
          pi = 0;
          pf++;
        end
      end
      cycles++;
    end
    L_wr_valid = 1'b0;
    L_in_en    = 1'b0;
    L_done     = 1'b0;
    checkOutput("tput frames", framesDone, 4);
    checkOutput("tput bank_full", L_bank_full, 2'b00);
    checkOutput("tput err", L_err, 0);
  endtask

  initial begin
    s_reset_n = 1'b0; s_wr_valid = 1'b1; s_wr_data = 16'hFFFF;
    s_in_en = 1'b1; s_in_addr = '0; s_done = 1'b1;
    L_reset_n = 1'b0; L_wr_valid = 1'b0; L_wr_data = '0;
    L_in_en = 1'b0; L_in_addr = '0; L_done = 1'b0;
    #1;
    tick();
    checkOutput("rst wr_ready", s_wr_ready, 0);
    checkOutput("rst bank_we", s_bank_we, 2'b00);
    checkOutput("rst bank_re", s_bank_re, 2'b00);
    checkOutput("rst bank_full", s_bank_full, 2'b00);
    checkOutput("rst dense_start", s_dense_start, 0);
    checkOutput("rst frame_done", s_frame_done, 0);
    checkOutput("rst err", s_err, 0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    s_reset_n = 1'b1;
    L_reset_n = 1'b1;
    tick();

    $display("[TB] single frame");
    for (int i = 0; i < SN; i++) begin
      applyStimulus(1'b1, i + 1, 1'b0, 0, 1'b0);
      checkOutput("t1 we", s_bank_we, 2'b01);
      checkOutput("t1 waddr", s_bank_waddr, i);
      checkOutput("t1 wdata", s_bank_wdata, i + 1);
      tick();
    end
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("t1 full", s_bank_full, 2'b01);
    checkOutput("t1 start early", s_dense_start, 0);
    tick();
    checkOutput("t1 start", s_dense_start, 1);
    tick();
    checkOutput("t1 start width", s_dense_start, 0);
    readFrame(2'b01, 1, "t1 rd");
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
    checkOutput("t1 fd early", s_frame_done, 0);
    tick();
    checkOutput("t1 frame_done", s_frame_done, 1);
    checkOutput("t1 full after", s_bank_full, 2'b00);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    checkOutput("t1 fd width", s_frame_done, 0);
    checkOutput("t1 err", s_err, 0);

    $display("[TB] backpressure");
    doReset();
    pushFrame(10, 2'b01, "t2 f1");
    pushFrame(20, 2'b10, "t2 f2");
    applyStimulus(1'b1, 30, 1'b0, 0, 1'b0);
    checkOutput("t2 full", s_bank_full, 2'b11);
    checkOutput("t2 ready", s_wr_ready, 0);
    checkOutput("t2 we", s_bank_we, 2'b00);
    tick();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 30, 1'b0, 0, 1'b0);
      checkOutput("t2 ready stall", s_wr_ready, 0);
      tick();
    end
    applyStimulus(1'b1, 30, 1'b0, 0, 1'b1);
    checkOutput("t2 ready at done", s_wr_ready, 0);
    tick();
    checkOutput("t2 frame_done", s_frame_done, 1);
    for (int i = 0; i < SN; i++) begin
      applyStimulus(1'b1, 30 + i, 1'b0, 0, 1'b0);
      checkOutput("t2 f3 we", s_bank_we, 2'b01);
      checkOutput("t2 f3 waddr", s_bank_waddr, i);
      tick();
      if (i == 0) checkOutput("t2 start f2", s_dense_start, 1);
    end
    s_wr_valid = 1'b0;
    checkOutput("t2 full f3", s_bank_full, 2'b11);
    readFrame(2'b10, 20, "t2 rd f2");
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    checkOutput("t2 frame_done f2", s_frame_done, 1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    checkOutput("t2 start f3", s_dense_start, 1);
    readFrame(2'b01, 30, "t2 rd f3");
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();

    $display("[TB] simultaneous write-complete and release");
    doReset();
    pushFrame(40, 2'b01, "t3 f0");
    for (int i = 0; i < SN - 1; i++) begin
      applyStimulus(1'b1, 50 + i, 1'b0, 0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 53, 1'b0, 0, 1'b1);
    checkOutput("t3 last we", s_bank_we, 2'b10);
    checkOutput("t3 last waddr", s_bank_waddr, 3);
    tick();
    s_wr_valid = 1'b0;
    checkOutput("t3 full", s_bank_full, 2'b10);
    checkOutput("t3 frame_done", s_frame_done, 1);
    checkOutput("t3 start early", s_dense_start, 0);
    checkOutput("t3 ready", s_wr_ready, 1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    checkOutput("t3 start", s_dense_start, 1);
    checkOutput("t3 full reading", s_bank_full, 2'b10);
    readFrame(2'b10, 50, "t3 rd");
    checkOutput("t3 err", s_err, 0);

    $display("[TB] reset mid-frame and mid-run");
    doReset();
    applyStimulus(1'b1, 60, 1'b0, 0, 1'b0);
    tick();
    applyStimulus(1'b1, 61, 1'b0, 0, 1'b0);
    tick();
    applyStimulus(1'b1, 62, 1'b0, 0, 1'b0);
    s_reset_n = 1'b0;
    #1;
    checkOutput("t4 rst ready", s_wr_ready, 0);
    checkOutput("t4 rst we", s_bank_we, 2'b00);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    s_reset_n = 1'b1;
    tick();
    pushFrame(70, 2'b01, "t4 f");
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);
    checkOutput("t4 start", s_dense_start, 1);
    checkOutput("t4 re run", s_bank_re, 2'b01);
    s_reset_n = 1'b0;
    #1;
    checkOutput("t4 rst re", s_bank_re, 2'b00);
    checkOutput("t4 rst start", s_dense_start, 0);
    checkOutput("t4 rst full", s_bank_full, 2'b00);
    checkOutput("t4 rst ready2", s_wr_ready, 0);
    checkOutput("t4 rst err", s_err, 0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    s_reset_n = 1'b1;
    tick();
    pushFrame(80, 2'b01, "t4 f2");
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    readFrame(2'b01, 80, "t4 rd");
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    tick();

    $display("[TB] protocol errors");
    doReset();
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    checkOutput("t5 err done", s_err, 1);
    checkOutput("t5 no frame_done", s_frame_done, 0);
    checkOutput("t5 full", s_bank_full, 2'b00);
    checkOutput("t5 ready", s_wr_ready, 1);
    applyStimulus(1'b0, 0, 1'b1, 2, 1'b0);
    checkOutput("t5 re idle", s_bank_re, 2'b00);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    repeat (3) tick();
    checkOutput("t5 err sticky", s_err, 1);
    pushFrame(90, 2'b01, "t5 f");
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("t5 full after", s_bank_full, 2'b01);
    tick();
    checkOutput("t5 start", s_dense_start, 1);
    checkOutput("t5 err still", s_err, 1);

    $display("[TB] throughput at IN_DIM=%0d", LN);
    runThroughput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
